// File: rtl/multiport_regfile.sv
// multiport_regfile: register file with two combinational read ports and two
// write ports. Write port 1 wins when both ports hit the same address.
// After reset the storage is cleared by a sweep that writes one entry per cycle.
// While the sweep runs, init_busy is high, user writes are ignored and both
// read ports return 0.
// Optional feature: define MULTIPORT_REGFILE_BYPASS_EN to forward the current
// cycle's write data to a read port whose address matches an active write.
// Write port 1 takes priority over write port 0 for forwarding.
// When ZERO_REG is 1, entry 0 always reads as zero and writes to it are dropped.

module multiport_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              init_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              init_busy_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Entry 0 is read-only zero only when ZERO_REG is enabled.
    logic zero_en;
    assign zero_en = (ZERO_REG != 0);

    // Each write port is qualified by its enable, the zero-register rule and
    // the sweep state.
    logic wr0_ok, wr1_ok;
    assign wr0_ok = we0 && (state_q == S_READY) && !(zero_en && (waddr0 == '0));
    assign wr1_ok = we1 && (state_q == S_READY) && !(zero_en && (waddr1 == '0));

    // Clear-sweep FSM: CLEAR walks the counter over every entry, then READY
    // holds until the next reset.
    // NOTE: state registers use non-blocking assignments so that every flop
    // samples the values from before the edge, whatever the block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_CLEAR;
            cnt_q       <= '0;
            init_busy_q <= 1'b1;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q     <= S_READY;
                        init_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_READY;
                    init_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign init_busy = init_busy_q;

    // Storage update: the sweep writes zeros; otherwise the user write ports
    // commit, with port 1 placed last so it wins on an address collision.
    // NOTE: the array has no reset branch. Only the sweep clears it, which
    // keeps it mappable to plain RAM or flops without a reset.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (wr0_ok) mem_q[waddr0] <= wdata0;
            if (wr1_ok) mem_q[waddr1] <= wdata1;
        end
    end

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;

    // Combinational read ports: zero while clearing or for entry 0, else the
    // stored value, optionally overridden by this cycle's write data.
    // NOTE: every output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            if ((state_q == S_READY) && !(zero_en && (rd_addr[p] == '0))) begin
                rd_data[p] = mem_q[rd_addr[p]];
`ifdef MULTIPORT_REGFILE_BYPASS_EN
                if (we0 && (waddr0 == rd_addr[p])) rd_data[p] = wdata0;
                if (we1 && (waddr1 == rd_addr[p])) rd_data[p] = wdata1;
`else
`endif
            end
        end
    end

    assign rd_data_a = rd_data[0];
    assign rd_data_b = rd_data[1];

endmodule

// File: tb/tb_multiport_regfile.sv
// Testbench for multiport_regfile. The stimulus process drives directed
// vectors and queues the expected values. A monitor process checks those
// values against the DUT outputs on the falling clock edge.
module tb_multiport_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
`ifdef MULTIPORT_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, waddr0, waddr1;
    logic [DATA_W-1:0] rd_data_a, rd_data_b, wdata0, wdata1;
    logic              we0, we1, init_busy;

    multiport_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .we0       (we0),
        .waddr0    (waddr0),
        .wdata0    (wdata0),
        .we1       (we1),
        .waddr1    (waddr1),
        .wdata1    (wdata1),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    // sel: 0 = rd_data_a, 1 = rd_data_b, 2 = init_busy
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_v(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are stable mid-cycle, so every expectation queued
    // for this cycle is checked on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                exp_t e;
                logic [31:0] act;
                e = exp_q.pop_front();
                case (e.sel)
                    0:       act = rd_data_a;
                    1:       act = rd_data_b;
                    default: act = {31'd0, init_busy};
                endcase
                check(e.name, act, e.exp);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_writes();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    endtask

    initial begin
        rst = 1'b1;
        rd_addr_a = 5'd4; rd_addr_b = 5'd9;
        idle_writes();

        // Reset state.
        cyc();
        expect_v("rst_busy", 2, 32'd1);
        expect_v("rst_rda", 0, 32'd0);
        expect_v("rst_rdb", 1, 32'd0);
        cyc();

        // First sweep, interrupted by reset at count 10.
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            expect_v("sweep1_busy", 2, 32'd1);
            cyc();
        end
        rst = 1'b1;
        expect_v("midrst_busy", 2, 32'd1);
        cyc();
        rst = 1'b0;

        // A full restarted sweep of DEPTH cycles. A write to address 4 and a
        // read of address 4 are issued late in the sweep.
        for (int i = 0; i < DEPTH; i++) begin
            expect_v("sweep2_busy", 2, 32'd1);
            if (i == 20) begin
                we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h55;
                rd_addr_a = 5'd4;
                expect_v("sweep_rd_zero", 0, 32'd0);
            end
            cyc();
            idle_writes();
        end
        expect_v("ready_busy", 2, 32'd0);

        // Every address reads 0 after the sweep; address 4 shows the dropped write.
        for (int k = 0; k < DEPTH / 2; k++) begin
            rd_addr_a = ADDR_W'(2 * k);
            rd_addr_b = ADDR_W'(2 * k + 1);
            expect_v("clr_rda", 0, 32'd0);
            expect_v("clr_rdb", 1, 32'd0);
            cyc();
        end

        // Same-address write collision: port 1 wins.
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h1111;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h2222;
        rd_addr_a = 5'd7;
        expect_v("conflict_same_cycle", 0, BYP ? 32'h2222 : 32'h0);
        cyc();
        idle_writes();
        expect_v("conflict_next", 0, 32'h2222);
        cyc();

        // Entry 0 stays zero, even under forwarding.
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hDEADBEEF;
        rd_addr_a = 5'd0; rd_addr_b = 5'd0;
        expect_v("zero_same_a", 0, 32'd0);
        expect_v("zero_same_b", 1, 32'd0);
        cyc();
        idle_writes();
        expect_v("zero_next_a", 0, 32'd0);
        cyc();

        // Forwarding of a port 1 write to read port B.
        we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'hA5A5A5A5;
        rd_addr_a = 5'd7; rd_addr_b = 5'd3;
        expect_v("bypass_b", 1, BYP ? 32'hA5A5A5A5 : 32'h0);
        expect_v("bypass_other_a", 0, 32'h2222);
        cyc();
        idle_writes();
        rd_addr_a = 5'd3;
        expect_v("bypass_next_a", 0, 32'hA5A5A5A5);
        expect_v("bypass_next_b", 1, 32'hA5A5A5A5);
        cyc();

        // Two distinct writes on the same edge.
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h5;
        we1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'h6;
        cyc();
        idle_writes();
        rd_addr_a = 5'd5; rd_addr_b = 5'd6;
        expect_v("dual_a", 0, 32'h5);
        expect_v("dual_b", 1, 32'h6);
        cyc();

        // A lone port 0 write overwrites an entry.
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h77;
        cyc();
        idle_writes();
        rd_addr_a = 5'd7; rd_addr_b = 5'd3;
        expect_v("p0_overwrite", 0, 32'h77);
        expect_v("p0_untouched", 1, 32'hA5A5A5A5);
        cyc();

        // Reset in mid-operation: outputs drop to zero and the contents are swept.
        rst = 1'b1;
        expect_v("oprst_busy", 2, 32'd1);
        expect_v("oprst_rda", 0, 32'd0);
        expect_v("oprst_rdb", 1, 32'd0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            expect_v("sweep3_busy", 2, 32'd1);
            cyc();
        end
        expect_v("sweep3_done", 2, 32'd0);
        expect_v("sweep3_a7", 0, 32'd0);
        expect_v("sweep3_b3", 1, 32'd0);
        cyc();

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data width of each entry.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width; depth DEPTH = 2**ADDR_W.
REQ-003 The block SHALL have parameter ZERO_REG, default 1, 1 = entry 0 hardwired to zero.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 rd_addr_a  input  ADDR_W  read port A address.
REQ-007 rd_data_a  output  DATA_W  read port A data.
REQ-008 rd_addr_b  input  ADDR_W  read port B address.
REQ-009 rd_data_b  output  DATA_W  read port B data.
REQ-010 we0 / waddr0 / wdata0  input  1 / ADDR_W / DATA_W  write port 0 enable, address, data.
REQ-011 we1 / waddr1 / wdata1  input  1 / ADDR_W / DATA_W  write port 1 enable, address, data.
REQ-012 init_busy  output  1  high while the post-reset clear sweep runs.

Function
REQ-013 Reads SHALL be combinational, zero latency; both ports independent, any address, including the same address on both.
REQ-014 Writes SHALL commit on the rising clk edge where the enable is high and init_busy is low.
REQ-015 When we0 and we1 are both high to the same address, port 1 SHALL win; port 0 data is discarded.
REQ-016 When ZERO_REG=1: writes to address 0 are discarded, and reads of address 0 return 0 on both ports, including under bypass.
REQ-017 The FSM SHALL have two states, CLEAR and READY; rst forces CLEAR with the sweep counter at 0.
REQ-018 In CLEAR: one entry per cycle is written to zero at the counter address, and the counter increments; after entry DEPTH-1 is cleared, the next state is READY.
REQ-019 The sweep SHALL take exactly DEPTH cycles after rst deassertion; init_busy is high in CLEAR and low in READY.
REQ-020 In CLEAR, user writes SHALL be ignored and both read ports SHALL return 0.
REQ-021 READY SHALL be held until the next rst; no other transition exists.
REQ-022 rst asserted mid-sweep or mid-operation SHALL restart the sweep from address 0.

Reset
REQ-023 On rst: state = CLEAR, counter = 0, init_busy = 1, rd_data_a = rd_data_b = 0.
REQ-024 Array contents SHALL NOT be reset directly; they are zeroed only by the sweep.

Configuration
REQ-025 Macro MULTIPORT_REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-026 When defined: a read address matching an active write address in READY returns that cycle's write data (port 1 over port 0, ZERO_REG rule still applies).
REQ-027 When not defined: reads return the stored value; new data is visible from the cycle after the commit edge.

Verification
REQ-028 Sweep: release rst, DEPTH=32 -> init_busy high exactly 32 cycles; then reading all 32 addresses returns 0.
REQ-029 Write conflict: we0=we1=1, waddr0=waddr1=7, wdata0=0x1111, wdata1=0x2222 -> address 7 reads 0x2222 next cycle.
REQ-030 Zero register: we0=1, waddr0=0, wdata0=0xDEADBEEF -> rd_data_a at address 0 reads 0 (ZERO_REG=1).
REQ-031 Bypass: we1=1, waddr1=3, wdata1=0xA5A5A5A5 with rd_addr_b=3 in the same cycle -> 0xA5A5A5A5 with macro defined; old value 0 without it.
REQ-032 Mid-sweep reset: assert rst at sweep count 10, then release -> init_busy high a further 32 cycles; a write of 0x55 to address 4 during the sweep is dropped (reads 0 after).
REQ-033 Dual distinct writes: address 5 = 0x5 and address 6 = 0x6 on the same edge -> port A and port B read 0x5 and 0x6.
